// File: rtl/user_rom_pkg.sv
// Shared types for the user-domain pipelined ROM: OBI configuration, request/response
// structs for the 32- and 64-bit bus flavours, and the out-of-range address check.
package user_rom_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};
  localparam obi_cfg_t Obi64Config      = '{AddrWidth: 32, DataWidth: 64, IdWidth: 4};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_32_t;

  typedef struct packed {
    logic      req;
    obi_a_32_t a;
  } obi_req_32_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_32_t;

  typedef struct packed {
    logic      gnt;
    logic      rvalid;
    obi_r_32_t r;
  } obi_rsp_32_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [3:0]  aid;
  } obi_a_64_t;

  typedef struct packed {
    logic      req;
    obi_a_64_t a;
  } obi_req_64_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_64_t;

  typedef struct packed {
    logic      gnt;
    logic      rvalid;
    obi_r_64_t r;
  } obi_rsp_64_t;

  // A word index at or beyond the ROM depth is out of range; this also covers any
  // address bit set above the index field, since such an index is >= 2**idx_bits.
  function automatic logic rom_oob(input logic [63:0] addr, input int unsigned off_bits,
                                   input int unsigned idx_bits, input int unsigned num_words);
    logic [63:0] word_idx;
    word_idx = addr >> off_bits;
    return ((word_idx >> idx_bits) != '0) || (word_idx >= 64'(num_words));
  endfunction

endpackage

// File: rtl/user_rom_pipe_stage.sv
// One pipeline stage of the ROM: registers the request metadata and, when HasData is
// set, the read word; otherwise the data input passes straight through.
module user_rom_pipe_stage
  import user_rom_pkg::*;
#(
  parameter type         meta_t    = logic,
  parameter int unsigned DataWidth = 32,
  parameter bit          HasData   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  meta_t                meta_i,
  input  logic [DataWidth-1:0] data_i,
  output meta_t                meta_o,
  output logic [DataWidth-1:0] data_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) meta_o <= '0;
    else         meta_o <= meta_i;
  end

  if (HasData) begin : g_data
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) data_o <= '0;
      else         data_o <= data_i;
    end
  end else begin : g_bypass
    assign data_o = data_i;
  end

endmodule

// File: rtl/user_rom_pipe.sv
// Parametrised, fully pipelined OBI read-only memory for the user domain.
// Grants every request, answers exactly Latency cycles later, in request order.
module user_rom_pipe
  import user_rom_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
  parameter type         obi_req_t = obi_req_32_t,
  parameter type         obi_rsp_t = obi_rsp_32_t,
  parameter int unsigned NumWords  = 8,
  parameter int unsigned Latency   = 2,
  parameter logic [ObiCfg.DataWidth-1:0] RomData [NumWords] = '{default: '0},
  parameter bit          ErrOnOob  = 1'b1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o
);

  localparam int unsigned DataWidth = ObiCfg.DataWidth;
  localparam int unsigned IdWidth   = ObiCfg.IdWidth;
  localparam int unsigned OffBits   = $clog2(DataWidth / 8);
  localparam int unsigned IdxBits   = (NumWords > 1) ? $clog2(NumWords) : 1;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic               oob;
    logic [IdxBits-1:0] idx;
    logic [IdWidth-1:0] id;
  } rom_meta_t;

  rom_meta_t            meta_q [Latency+1];
  rom_meta_t            rd_meta;
  rom_meta_t            out_meta;
  logic [DataWidth-1:0] rd_word;
  logic [DataWidth-1:0] last_data;
  logic                 unused_req;

  // Byte enables and write data have no effect on a ROM.
  assign unused_req = ^{obi_req_i.a.be, obi_req_i.a.wdata};

  assign meta_q[0] = rom_meta_t'{
    valid: obi_req_i.req,
    we:    obi_req_i.a.we,
    oob:   rom_oob(64'(obi_req_i.a.addr), OffBits, IdxBits, NumWords),
    idx:   obi_req_i.a.addr[OffBits +: IdxBits],
    id:    obi_req_i.a.aid
  };

  // With one cycle of latency the ROM is read combinationally from stage 1;
  // otherwise it is read from the second-to-last stage and registered.
  if (Latency >= 2) begin : g_rd_reg
    assign rd_meta = meta_q[Latency-1];
  end else begin : g_rd_comb
    assign rd_meta = meta_q[1];
  end

  always_comb begin
    rd_word = '0;
    if (rd_meta.valid && !rd_meta.we && !rd_meta.oob) begin
      for (int unsigned i = 0; i < NumWords; i++) begin
        if (rd_meta.idx == IdxBits'(i)) rd_word = RomData[i];
      end
    end
  end

  for (genvar k = 1; k <= Latency; k++) begin : g_stage
    if (k == Latency) begin : g_last
      user_rom_pipe_stage #(
        .meta_t   (rom_meta_t),
        .DataWidth(DataWidth),
        .HasData  (Latency >= 2)
      ) u_stage (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .meta_i(meta_q[k-1]),
        .data_i(rd_word),
        .meta_o(meta_q[k]),
        .data_o(last_data)
      );
    end else begin : g_mid
      logic [DataWidth-1:0] unused_data;
      user_rom_pipe_stage #(
        .meta_t   (rom_meta_t),
        .DataWidth(DataWidth),
        .HasData  (1'b0)
      ) u_stage (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .meta_i(meta_q[k-1]),
        .data_i('0),
        .meta_o(meta_q[k]),
        .data_o(unused_data)
      );
    end
  end

  assign out_meta = meta_q[Latency];

  // The bus stays all-zero whenever no response is presented.
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = out_meta.valid;
    if (out_meta.valid) begin
      obi_rsp_o.r.rdata = last_data;
      obi_rsp_o.r.rid   = out_meta.id;
      obi_rsp_o.r.err   = out_meta.we | (out_meta.oob & ErrOnOob);
    end
  end

endmodule

// File: tb/tb_user_rom_pipe.sv
// Scoreboard bench for user_rom_pipe: three instances (32-bit with and without OOB
// errors, 64-bit/Latency 4/5 words); stimulus pushes expectations, monitors pop them.
module tb_user_rom_pipe;
  import user_rom_pkg::*;

  typedef struct packed {
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic        err;
    int          cyc;
  } exp_t;

  localparam logic [31:0] ROM_A [8] = '{32'h1000, 32'h1001, 32'h1002, 32'h1003,
                                        32'h1004, 32'h1005, 32'h1006, 32'h1007};
  localparam logic [63:0] ROM_C [5] = '{64'h0123_4567_89ab_0000, 64'h0123_4567_89ab_0001,
                                        64'h0123_4567_89ab_0002, 64'h0123_4567_89ab_0003,
                                        64'h0123_4567_89ab_0004};

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  obi_req_32_t req_a;
  obi_rsp_32_t rsp_a, rsp_b;
  obi_req_64_t req_c;
  obi_rsp_64_t rsp_c;
  exp_t        q_a[$], q_b[$], q_c[$];
  exp_t        e_a, e_b, e_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  user_rom_pipe #(
    .ObiCfg(ObiDefaultConfig), .obi_req_t(obi_req_32_t), .obi_rsp_t(obi_rsp_32_t),
    .NumWords(8), .Latency(2), .RomData(ROM_A), .ErrOnOob(1'b1)
  ) dut_a (.clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_a), .obi_rsp_o(rsp_a));

  user_rom_pipe #(
    .ObiCfg(ObiDefaultConfig), .obi_req_t(obi_req_32_t), .obi_rsp_t(obi_rsp_32_t),
    .NumWords(8), .Latency(2), .RomData(ROM_A), .ErrOnOob(1'b0)
  ) dut_b (.clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_a), .obi_rsp_o(rsp_b));

  user_rom_pipe #(
    .ObiCfg(Obi64Config), .obi_req_t(obi_req_64_t), .obi_rsp_t(obi_rsp_64_t),
    .NumWords(5), .Latency(4), .RomData(ROM_C), .ErrOnOob(1'b1)
  ) dut_c (.clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_c), .obi_rsp_o(rsp_c));

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (rsp_a.rvalid) begin
      if (q_a.size() == 0) chk("a_unexpected_rvalid", 64'(rsp_a.rvalid), 64'd0);
      else begin
        e_a = q_a.pop_front();
        chk("a_rdata", 64'(rsp_a.r.rdata), e_a.rdata);
        chk("a_rid", 64'(rsp_a.r.rid), 64'(e_a.rid));
        chk("a_err", 64'(rsp_a.r.err), 64'(e_a.err));
        chk("a_cycle", 64'(cyc), 64'(e_a.cyc));
      end
    end else begin
      chk("a_idle_bus", 64'({rsp_a.r.rdata, rsp_a.r.rid, rsp_a.r.err, rsp_a.r.r_optional}), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (rsp_b.rvalid) begin
      if (q_b.size() == 0) chk("b_unexpected_rvalid", 64'(rsp_b.rvalid), 64'd0);
      else begin
        e_b = q_b.pop_front();
        chk("b_rdata", 64'(rsp_b.r.rdata), e_b.rdata);
        chk("b_rid", 64'(rsp_b.r.rid), 64'(e_b.rid));
        chk("b_err", 64'(rsp_b.r.err), 64'(e_b.err));
        chk("b_cycle", 64'(cyc), 64'(e_b.cyc));
      end
    end else begin
      chk("b_idle_bus", 64'({rsp_b.r.rdata, rsp_b.r.rid, rsp_b.r.err, rsp_b.r.r_optional}), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (rsp_c.rvalid) begin
      if (q_c.size() == 0) chk("c_unexpected_rvalid", 64'(rsp_c.rvalid), 64'd0);
      else begin
        e_c = q_c.pop_front();
        chk("c_rdata", rsp_c.r.rdata, e_c.rdata);
        chk("c_rid", 64'(rsp_c.r.rid), 64'(e_c.rid));
        chk("c_err", 64'(rsp_c.r.err), 64'(e_c.err));
        chk("c_cycle", 64'(cyc), 64'(e_c.cyc));
      end
    end else begin
      chk("c_idle_rdata", rsp_c.r.rdata, 64'd0);
      chk("c_idle_rid_err", 64'({rsp_c.r.rid, rsp_c.r.err, rsp_c.r.r_optional}), 64'd0);
    end
  end

  // Drives one request into dut_a/dut_b; the response is due Latency (2) cycles later.
  task automatic issue_ab(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] aid, input logic [31:0] exp_rdata,
                          input logic exp_err_a, input logic exp_err_b);
    @(posedge clk); #1;
    req_a.req     = 1'b1;
    req_a.a.addr  = addr;
    req_a.a.we    = we;
    req_a.a.be    = 4'hf;
    req_a.a.wdata = wdata;
    req_a.a.aid   = aid;
    q_a.push_back('{rdata: 64'(exp_rdata), rid: aid, err: exp_err_a, cyc: cyc + 2});
    q_b.push_back('{rdata: 64'(exp_rdata), rid: aid, err: exp_err_b, cyc: cyc + 2});
    #1 chk("ab_gnt", 64'({rsp_a.gnt, rsp_b.gnt}), 64'd3);
  endtask

  task automatic idle_ab();
    @(posedge clk); #1;
    req_a = '0;
  endtask

  task automatic issue_c(input logic [31:0] addr, input logic we, input logic [3:0] aid,
                         input logic [63:0] exp_rdata, input logic exp_err, input bit expect_rsp);
    @(posedge clk); #1;
    req_c.req     = 1'b1;
    req_c.a.addr  = addr;
    req_c.a.we    = we;
    req_c.a.be    = 8'hff;
    req_c.a.wdata = 64'hdead_beef_dead_beef;
    req_c.a.aid   = aid;
    if (expect_rsp) q_c.push_back('{rdata: exp_rdata, rid: aid, err: exp_err, cyc: cyc + 4});
    #1 chk("c_gnt", 64'(rsp_c.gnt), 64'd1);
  endtask

  task automatic idle_c();
    @(posedge clk); #1;
    req_c = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    chk("drain_pending", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0;
    req_c = '0;
    repeat (3) @(posedge clk);
    #1;
    req_a.req = 1'b1;
    req_c.req = 1'b1;
    #1;
    chk("reset_gnt", 64'({rsp_a.gnt, rsp_b.gnt, rsp_c.gnt}), 64'd7);
    chk("reset_rvalid", 64'({rsp_a.rvalid, rsp_b.rvalid, rsp_c.rvalid}), 64'd0);
    req_a = '0;
    req_c = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("idle_rvalid", 64'({rsp_a.rvalid, rsp_b.rvalid, rsp_c.rvalid}), 64'd0);

    issue_ab(32'h0000_000c, 1'b0, 32'h0, 4'd3, 32'h1003, 1'b0, 1'b0);
    idle_ab();
    drain(10);

    for (int i = 0; i < 8; i++)
      issue_ab(32'(i * 4), 1'b0, 32'h0, 4'(i), 32'h1000 + 32'(i), 1'b0, 1'b0);
    idle_ab();
    drain(20);

    issue_ab(32'h0000_0004, 1'b1, 32'h0000_dead, 4'd5, 32'h0, 1'b1, 1'b1);
    issue_ab(32'h0000_0004, 1'b0, 32'h0, 4'd6, 32'h1001, 1'b0, 1'b0);
    issue_ab(32'h0000_0020, 1'b0, 32'h0, 4'd1, 32'h0, 1'b1, 1'b0);
    issue_ab(32'h0000_1000, 1'b0, 32'h0, 4'd2, 32'h0, 1'b1, 1'b0);
    issue_ab(32'h0000_000e, 1'b0, 32'h0, 4'd4, 32'h1003, 1'b0, 1'b0);
    issue_ab(32'h0000_001c, 1'b0, 32'h0, 4'd15, 32'h1007, 1'b0, 1'b0);
    idle_ab();
    drain(20);

    issue_c(32'h0000_0020, 1'b0, 4'd9, 64'h0123_4567_89ab_0004, 1'b0, 1'b1);
    issue_c(32'h0000_0028, 1'b0, 4'd10, 64'h0, 1'b1, 1'b1);
    issue_c(32'h0000_0040, 1'b0, 4'd11, 64'h0, 1'b1, 1'b1);
    issue_c(32'h0000_0008, 1'b1, 4'd12, 64'h0, 1'b1, 1'b1);
    issue_c(32'h0000_0000, 1'b0, 4'd14, 64'h0123_4567_89ab_0000, 1'b0, 1'b1);
    idle_c();
    drain(20);

    // In-flight read flushed by a one-cycle reset two cycles after issue.
    issue_c(32'h0000_0020, 1'b0, 4'd7, 64'h0, 1'b0, 1'b0);
    idle_c();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    issue_c(32'h0000_0008, 1'b0, 4'd13, 64'h0123_4567_89ab_0001, 1'b0, 1'b1);
    idle_c();
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
